// File: rtl/spi_slave_sync.sv
// SPI slave with every SPI pin resynchronised into the clk_in domain.
// Mode set by CPOL/CPHA; word length and bit order are parameters.
module spi_slave_sync #(
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  spi_sclk_in,
  input  logic                  spi_mosi_in,
  input  logic                  spi_cs_n_in,
  output logic                  spi_miso_out,
  output logic                  spi_miso_oe_out,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  output logic                  tx_load_out,
  output logic                  rx_valid_out,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  frame_start_out,
  output logic                  frame_end_out,
  output logic                  partial_out
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  logic [1:0] warm;
  logic       armed;

  logic [0:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  first_shift;
  logic                  reload_pend;

  logic sclk_rise;
  logic sclk_fall;
  logic sample_edge;
  logic shift_edge;
  logic cs_fall;
  logic cs_rise;
  logic mosi_bit;
  logic miso_bit;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] tx_next;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sclk_q <= {3{CPOL}};
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk_in};
      cs_q   <= {cs_q[1:0], spi_cs_n_in};
      mosi_q <= {mosi_q[0], spi_mosi_in};
    end
  end

  // The CS pipe resets to "high"; a low CS at release must not look
  // like a fresh falling edge, so CS has to be seen high first.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      warm  <= 2'd0;
      armed <= 1'b0;
    end else begin
      if (warm != 2'd2) warm <= warm + 2'd1;
      if (warm == 2'd2 && cs_q[1]) armed <= 1'b1;
    end
  end

  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign cs_fall     = cs_q[2] & ~cs_q[1] & armed;
  assign cs_rise     = ~cs_q[2] & cs_q[1];
  assign mosi_bit    = mosi_q[1];

  assign rx_next = MSB_FIRST ?
    {rx_shift[DATA_WIDTH-2:0], mosi_bit} :
    {mosi_bit, rx_shift[DATA_WIDTH-1:1]};
  assign tx_next = MSB_FIRST ?
    {tx_shift[DATA_WIDTH-2:0], 1'b0} :
    {1'b0, tx_shift[DATA_WIDTH-1:1]};
  assign miso_bit = MSB_FIRST ?
    tx_shift[DATA_WIDTH-1] : tx_shift[0];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= ST_IDLE;
      bit_cnt         <= '0;
      tx_shift        <= '0;
      rx_shift        <= '0;
      rx_data_out     <= '0;
      rx_valid_out    <= 1'b0;
      tx_load_out     <= 1'b0;
      frame_start_out <= 1'b0;
      frame_end_out   <= 1'b0;
      partial_out     <= 1'b0;
      first_shift     <= 1'b0;
      reload_pend     <= 1'b0;
    end else begin
      rx_valid_out    <= 1'b0;
      tx_load_out     <= 1'b0;
      frame_start_out <= 1'b0;
      frame_end_out   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state           <= ST_ACTIVE;
            bit_cnt         <= '0;
            tx_shift        <= tx_data_in;
            tx_load_out     <= 1'b1;
            frame_start_out <= 1'b1;
            partial_out     <= 1'b0;
            first_shift     <= 1'b1;
            reload_pend     <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          // CS release wins over a coincident sample edge.
          if (cs_rise) begin
            state         <= ST_IDLE;
            frame_end_out <= 1'b1;
            if (bit_cnt != '0) partial_out <= 1'b1;
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            if (bit_cnt == CNT_LAST) begin
              bit_cnt      <= '0;
              rx_data_out  <= rx_next;
              rx_valid_out <= 1'b1;
              reload_pend  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end else if (shift_edge) begin
            first_shift <= 1'b0;
            // CPHA=1: the first leading edge precedes any sampled bit.
            if (!(CPHA && first_shift)) begin
              if (reload_pend) begin
                tx_shift    <= tx_data_in;
                tx_load_out <= 1'b1;
                reload_pend <= 1'b0;
              end else begin
                tx_shift <= tx_next;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign spi_miso_oe_out = (state == ST_ACTIVE);
  assign spi_miso_out    = (state == ST_ACTIVE) & miso_bit;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench: four slaves in modes 0..3 driven by a behavioural SPI master.
// Words and MISO streams are compared with values the master chose.
module tb_spi_slave_sync;

  localparam int H = 50;
  localparam logic [3:0] CPOL_V = 4'b1100;
  localparam logic [3:0] CPHA_V = 4'b1010;
  localparam logic [3:0] MSB_V  = 4'b0111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  sclk;
  logic [3:0]  cs_n;
  logic        mosi;
  logic [15:0] txd;
  logic [3:0]  miso, oe, txl, rxv, fs, fe, part;
  logic [7:0]  rxd0, rxd1, rxd2;
  logic [15:0] rxd3;

  spi_slave_sync #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0),
    .MSB_FIRST(1'b1)) u0 (
    .clk_in(clk), .rst_in(rst), .spi_sclk_in(sclk[0]),
    .spi_mosi_in(mosi), .spi_cs_n_in(cs_n[0]),
    .spi_miso_out(miso[0]), .spi_miso_oe_out(oe[0]),
    .tx_data_in(txd[7:0]), .tx_load_out(txl[0]),
    .rx_valid_out(rxv[0]), .rx_data_out(rxd0),
    .frame_start_out(fs[0]), .frame_end_out(fe[0]),
    .partial_out(part[0]));

  spi_slave_sync #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b1),
    .MSB_FIRST(1'b1)) u1 (
    .clk_in(clk), .rst_in(rst), .spi_sclk_in(sclk[1]),
    .spi_mosi_in(mosi), .spi_cs_n_in(cs_n[1]),
    .spi_miso_out(miso[1]), .spi_miso_oe_out(oe[1]),
    .tx_data_in(txd[7:0]), .tx_load_out(txl[1]),
    .rx_valid_out(rxv[1]), .rx_data_out(rxd1),
    .frame_start_out(fs[1]), .frame_end_out(fe[1]),
    .partial_out(part[1]));

  spi_slave_sync #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b0),
    .MSB_FIRST(1'b1)) u2 (
    .clk_in(clk), .rst_in(rst), .spi_sclk_in(sclk[2]),
    .spi_mosi_in(mosi), .spi_cs_n_in(cs_n[2]),
    .spi_miso_out(miso[2]), .spi_miso_oe_out(oe[2]),
    .tx_data_in(txd[7:0]), .tx_load_out(txl[2]),
    .rx_valid_out(rxv[2]), .rx_data_out(rxd2),
    .frame_start_out(fs[2]), .frame_end_out(fe[2]),
    .partial_out(part[2]));

  spi_slave_sync #(.DATA_WIDTH(16), .CPOL(1'b1), .CPHA(1'b1),
    .MSB_FIRST(1'b0)) u3 (
    .clk_in(clk), .rst_in(rst), .spi_sclk_in(sclk[3]),
    .spi_mosi_in(mosi), .spi_cs_n_in(cs_n[3]),
    .spi_miso_out(miso[3]), .spi_miso_oe_out(oe[3]),
    .tx_data_in(txd), .tx_load_out(txl[3]),
    .rx_valid_out(rxv[3]), .rx_data_out(rxd3),
    .frame_start_out(fs[3]), .frame_end_out(fe[3]),
    .partial_out(part[3]));

  int n_chk = 0;
  int n_fail = 0;
  int n_rxv[4], n_txl[4], n_fs[4], n_fe[4], n_oe[4];
  int viol = 0;
  logic [31:0] rxw [4][8];
  logic [3:0] p_rxv = '0, p_txl = '0, p_fs = '0, p_fe = '0;

  function automatic int wid(input int d);
    return (d == 3) ? 16 : 8;
  endfunction

  function automatic logic [31:0] mask(input int d);
    return (d == 3) ? 32'hFFFF : 32'hFF;
  endfunction

  function automatic logic [31:0] get_rxd(input int d);
    case (d)
      0: return {24'd0, rxd0};
      1: return {24'd0, rxd1};
      2: return {24'd0, rxd2};
      default: return {16'd0, rxd3};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (((rxv & p_rxv) | (txl & p_txl) | (fs & p_fs) | (fe & p_fe)) != 4'd0)
      viol++;
    p_rxv = rxv;
    p_txl = txl;
    p_fs  = fs;
    p_fe  = fe;
    for (int d = 0; d < 4; d++) begin
      if (rxv[d]) begin
        rxw[d][n_rxv[d] % 8] = get_rxd(d);
        n_rxv[d]++;
      end
      if (txl[d]) n_txl[d]++;
      if (fs[d]) n_fs[d]++;
      if (fe[d]) n_fe[d]++;
      if (oe[d]) n_oe[d]++;
    end
  end

  task automatic clr();
    for (int d = 0; d < 4; d++) begin
      n_rxv[d] = 0;
      n_txl[d] = 0;
      n_fs[d]  = 0;
      n_fe[d]  = 0;
      n_oe[d]  = 0;
    end
  endtask

  task automatic cs_dn(input int d);
    cs_n[d] = 1'b0;
    #(2*H);
  endtask

  task automatic cs_up(input int d);
    #H;
    cs_n[d] = 1'b1;
    #(2*H);
  endtask

  // Master: sends nb bits of w in the slave's bit order, returns MISO.
  task automatic spi_word(input int d, input logic [31:0] w,
                          input int nb, output logic [31:0] mw);
    int p;
    logic b;
    mw = '0;
    for (int i = 0; i < nb; i++) begin
      p = MSB_V[d] ? wid(d) - 1 - i : i;
      if (!CPHA_V[d]) begin
        mosi = w[p];
        #H;
        b = miso[d];
        sclk[d] = ~CPOL_V[d];
        #H;
        sclk[d] = CPOL_V[d];
      end else begin
        sclk[d] = ~CPOL_V[d];
        mosi = w[p];
        #H;
        b = miso[d];
        sclk[d] = CPOL_V[d];
        #H;
      end
      mw[p] = b;
    end
  endtask

  task automatic toggle8(input int d);
    for (int i = 0; i < 8; i++) begin
      sclk[d] = ~sclk[d];
      #H;
    end
  endtask

  logic [31:0] mw, tx, prev;
  logic [31:0] wds [2];
  int d, nw;

  initial begin
    sclk = CPOL_V;
    cs_n = '1;
    mosi = 1'b0;
    txd  = '0;
    clr();
    #40;
    chk("rst_oe", {28'd0, oe}, 0);
    chk("rst_miso", {28'd0, miso}, 0);
    chk("rst_part", {28'd0, part}, 0);
    chk("rst_pulse", {16'd0, rxv, txl, fs, fe}, 0);
    chk("rst_rxd8", {8'd0, rxd0, rxd1, rxd2}, 0);
    chk("rst_rxd16", {16'd0, rxd3}, 0);
    rst = 1'b0;
    #100;

    clr();
    for (int k = 0; k < 4; k++) toggle8(k);
    for (int k = 0; k < 4; k++) begin
      chk("idle_pulses", n_rxv[k] + n_txl[k] + n_fs[k] + n_fe[k], 0);
      chk("idle_oe", n_oe[k], 0);
    end

    clr();
    txd = 16'h003C;
    cs_dn(0);
    spi_word(0, 32'hA5, 8, mw);
    chk("m0_miso", mw, 32'h3C);
    cs_up(0);
    chk("m0_rx_cnt", n_rxv[0], 1);
    chk("m0_rx_word", rxw[0][0], 32'hA5);
    chk("m0_txl_cnt", n_txl[0], 2);
    chk("m0_part", {31'd0, part[0]}, 0);

    clr();
    txd = 16'h5AC3;
    cs_dn(3);
    spi_word(3, 32'h1234, 16, mw);
    chk("m3_miso0", mw, 32'h5AC3);
    spi_word(3, 32'hBEEF, 16, mw);
    chk("m3_miso1", mw, 32'h5AC3);
    cs_up(3);
    chk("m3_rx_cnt", n_rxv[3], 2);
    chk("m3_w0", rxw[3][0], 32'h1234);
    chk("m3_w1", rxw[3][1], 32'hBEEF);
    chk("m3_fs", n_fs[3], 1);
    chk("m3_fe", n_fe[3], 1);

    for (int it = 0; it < 12; it++) begin
      d  = int'($urandom_range(3, 0));
      nw = int'($urandom_range(2, 1));
      tx = $urandom & mask(d);
      txd = tx[15:0];
      clr();
      cs_dn(d);
      for (int k = 0; k < nw; k++) begin
        wds[k] = $urandom & mask(d);
        spi_word(d, wds[k], wid(d), mw);
        chk("rnd_miso", mw, tx);
      end
      cs_up(d);
      chk("rnd_rx_cnt", n_rxv[d], nw);
      chk("rnd_w0", rxw[d][0], wds[0]);
      if (nw == 2) chk("rnd_w1", rxw[d][1], wds[1]);
      chk("rnd_txl", n_txl[d], CPHA_V[d] ? nw : nw + 1);
      chk("rnd_fe", n_fe[d], 1);
      chk("rnd_part", {31'd0, part[d]}, 0);
    end

    prev = get_rxd(1);
    clr();
    cs_dn(1);
    spi_word(1, 32'h6D, 5, mw);
    cs_up(1);
    chk("m1_part_rx", n_rxv[1], 0);
    chk("m1_part", {31'd0, part[1]}, 1);
    chk("m1_rxd_hold", get_rxd(1), prev);
    cs_dn(1);
    chk("m1_part_clr", {31'd0, part[1]}, 0);
    spi_word(1, 32'hC7, 8, mw);
    cs_up(1);
    chk("m1_next_rx", get_rxd(1), 32'hC7);

    prev = get_rxd(0);
    clr();
    cs_dn(0);
    spi_word(0, 32'hFF, 7, mw);
    mosi = 1'b1;
    #H;
    sclk[0] = 1'b1;
    cs_n[0] = 1'b1;
    #H;
    sclk[0] = 1'b0;
    #(2*H);
    chk("coin_rx", n_rxv[0], 0);
    chk("coin_fe", n_fe[0], 1);
    chk("coin_part", {31'd0, part[0]}, 1);
    chk("coin_rxd", get_rxd(0), prev);

    clr();
    cs_dn(2);
    spi_word(2, 32'hE0, 3, mw);
    rst = 1'b1;
    #30;
    chk("m2_rst_rxd", get_rxd(2), 0);
    rst = 1'b0;
    #(2*H);
    chk("m2_rst_oe", {31'd0, oe[2]}, 0);
    chk("m2_rst_fe", n_fe[2] + n_rxv[2], 0);
    clr();
    toggle8(2);
    chk("m2_ign_pulse", n_rxv[2] + n_fs[2] + n_txl[2], 0);
    chk("m2_ign_oe", n_oe[2], 0);
    cs_up(2);
    clr();
    cs_dn(2);
    spi_word(2, 32'h81, 8, mw);
    cs_up(2);
    chk("m2_rx_cnt", n_rxv[2], 1);
    chk("m2_rx_word", rxw[2][0], 32'h81);

    chk("consec_pulse", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8: bits per word, legal range 4..32.
REQ-002 SHALL provide parameter CPOL, default 0: SCLK idle level.
REQ-003 SHALL provide parameter CPHA, default 0: 0 = sample on the leading edge, 1 = sample on the trailing edge.
REQ-004 SHALL provide parameter MSB_FIRST, default 1: 1 = MSB first on both MOSI and MISO, 0 = LSB first.
REQ-005 SHALL provide port clk_in, input, 1 bit: single system clock; all state is clocked on its rising edge.
REQ-006 SHALL provide port rst_in, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL provide port spi_sclk_in, input, 1 bit: asynchronous SPI clock.
REQ-008 SHALL provide port spi_mosi_in, input, 1 bit: asynchronous serial data in.
REQ-009 SHALL provide port spi_cs_n_in, input, 1 bit: asynchronous chip select, active-low.
REQ-010 SHALL provide port spi_miso_out, output, 1 bit: serial data out.
REQ-011 SHALL provide port spi_miso_oe_out, output, 1 bit: MISO output enable, high while selected.
REQ-012 SHALL provide port tx_data_in, input, DATA_WIDTH bits: next word to transmit.
REQ-013 SHALL provide port tx_load_out, output, 1 bit: one-cycle pulse indicating tx_data_in was captured.
REQ-014 SHALL provide port rx_valid_out, output, 1 bit: one-cycle pulse indicating rx_data_out holds a new word.
REQ-015 SHALL provide port rx_data_out, output, DATA_WIDTH bits: last complete received word, held between pulses.
REQ-016 SHALL provide port frame_start_out, output, 1 bit: one-cycle pulse on CS assertion.
REQ-017 SHALL provide port frame_end_out, output, 1 bit: one-cycle pulse on CS deassertion.
REQ-018 SHALL provide port partial_out, output, 1 bit: level, set when a frame ended mid-word; cleared at the next frame start.

Function
REQ-019 SHALL pass spi_sclk_in, spi_mosi_in and spi_cs_n_in through two-flop synchronisers, plus a third flop used for edge detection; clk_in SHALL be at least 4x the SCLK frequency.
REQ-020 SHALL define the sample edge as rising when CPOL xor CPHA = 0, otherwise falling; the shift edge SHALL be the opposite edge.
REQ-021 SHALL implement an FSM with two states: IDLE (CS high) and ACTIVE; the IDLE->ACTIVE transition occurs on a synchronised CS falling edge, and ACTIVE->IDLE on a synchronised CS rising edge.
REQ-022 On entering ACTIVE, the block SHALL clear the bit counter, load tx_data_in into the TX shifter, and pulse both tx_load_out and frame_start_out in the same cycle.
REQ-023 On each sample edge in ACTIVE, the block SHALL shift the synchronised MOSI into the RX shifter (direction per MSB_FIRST) and increment the bit counter.
REQ-024 When the counter reaches DATA_WIDTH-1 on a sample edge, the block SHALL wrap the counter to 0, write the completed word to rx_data_out, and pulse rx_valid_out one clk_in cycle after that edge's detection cycle.
REQ-025 On each shift edge in ACTIVE, the block SHALL advance the TX shifter, except on the first shift edge of a frame when CPHA = 1.
REQ-026 On the shift edge that follows a word-completing sample edge, the block SHALL reload the TX shifter from tx_data_in and pulse tx_load_out.
REQ-027 With CPHA = 0, the first MISO bit SHALL be valid in the cycle after the CS falling edge is detected.
REQ-028 spi_miso_out SHALL equal the TX shifter's current output bit while in ACTIVE, and 0 in IDLE; spi_miso_oe_out SHALL be 1 exactly while in ACTIVE.
REQ-029 A CS rising edge and a sample edge detected in the same cycle SHALL be resolved in favour of CS: the edge is ignored, no rx_valid_out pulse is generated, and frame_end_out pulses.
REQ-030 If the counter is nonzero at frame end, the block SHALL set partial_out and discard the partial word, leaving rx_data_out unchanged.
REQ-031 SCLK edges detected while in IDLE SHALL be ignored.
REQ-032 rx_valid_out, tx_load_out, frame_start_out and frame_end_out SHALL never be high for two consecutive cycles.

Reset
REQ-033 While rst_in = 1, the block SHALL hold: FSM = IDLE, counter = 0, shifters = 0, rx_data_out = 0, all pulse outputs = 0, partial_out = 0, spi_miso_out = 0, spi_miso_oe_out = 0, and synchroniser flops = CS high / SCLK at CPOL / MOSI 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no rx_valid_out or frame_end_out pulse; after release with CS still low, the block SHALL remain IDLE until a new CS falling edge.

Verification
REQ-035 Mode 0, W = 8: CS low, MOSI sends 0xA5, tx_data_in = 0x3C -> one rx_valid_out with rx_data_out = 0xA5; MISO bits 0,0,1,1,1,1,0,0; tx_load_out pulses twice (at frame start and after bit 8).
REQ-036 Mode 3, W = 16, MSB_FIRST = 0: send 0x1234 then 0xBEEF in one frame -> two rx_valid_out pulses carrying 0x1234 then 0xBEEF; frame_start_out = 1 and frame_end_out = 1 (one pulse each).
REQ-037 Mode 1, W = 8: CS rises after 5 bits -> no rx_valid_out, partial_out = 1, rx_data_out unchanged; the next frame start clears partial_out.
REQ-038 Mode 0: CS rising coincident with the 8th sample edge -> no rx_valid_out, frame_end_out pulses, partial_out = 1.
REQ-039 Mode 2: rst_in pulsed after bit 3 with CS held low -> all outputs return to reset values; SCLK toggles ignored until CS toggles; the next full frame of 0x81 is received correctly.
REQ-040 All modes: SCLK toggled 8 times with CS high -> no pulse outputs asserted and spi_miso_oe_out = 0 throughout.
